aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 121 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: steps the datapath through LOAD, AddRoundKey, SubBytes, ShiftRows and
// MixColumns strobes, with a key-schedule handshake. Define AES_ROUND_CTRL_DECRYPT_EN for inverse cipher.
module aes_round_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
`ifdef AES_ROUND_CTRL_DECRYPT_EN
   input  logic       dec_mode,
`endif
   input  logic       key_ready,
   output logic       key_req,
   output logic [3:0] round_idx,
   output logic [3:0] key_idx,
   output logic       load_state,
   output logic       sub_en,
   output logic       shift_en,
   output logic       mix_en,
   output logic       ark_en,
   output logic       inv,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StKeyWait,
      StSub,
      StShift,
      StMix,
      StArk,
      StDone
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic       inv_q;
   logic       last_round;

   assign last_round = (round_q == 4'd10);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         round_q <= 4'd0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
      end
   end

`ifdef AES_ROUND_CTRL_DECRYPT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         inv_q <= 1'b0;
      end else if (state_q == StIdle && start) begin
         inv_q <= dec_mode;
      end
   end
`else
   assign inv_q = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               round_d = 4'd0;
            end
         end
         StLoad:    state_d = StKeyWait;
         StKeyWait: if (key_ready) state_d = StArk;
         StArk: begin
            if (last_round) begin
               state_d = StDone;
            end else if (!inv_q) begin
               round_d = round_q + 4'd1;
               state_d = StSub;
            end else if (round_q == 4'd0) begin
               round_d = 4'd1;
               state_d = StShift;
            end else begin
               // Inverse middle rounds: InvMixColumns follows AddRoundKey, round advances after it
               state_d = StMix;
            end
         end
         StSub:   state_d = inv_q ? StKeyWait : StShift;
         StShift: begin
            if (inv_q)           state_d = StSub;
            else if (last_round) state_d = StKeyWait;
            else                 state_d = StMix;
         end
         StMix: begin
            if (inv_q) begin
               round_d = round_q + 4'd1;
               state_d = StShift;
            end else begin
               state_d = StKeyWait;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign round_idx  = round_q;
   assign key_idx    = inv_q ? (4'd10 - round_q) : round_q;
   assign inv        = inv_q;
   assign key_req    = (state_q == StKeyWait);
   assign load_state = (state_q == StLoad);
   assign sub_en     = (state_q == StSub);
   assign shift_en   = (state_q == StShift);
   assign mix_en     = (state_q == StMix);
   assign ark_en     = (state_q == StArk);
   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StDone);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: table of block runs (stalls, restarts, decrypt) plus reset
// sequences. Define AES_ROUND_CTRL_DECRYPT_EN to include the inverse-cipher rows.
module tb_aes_round_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, key_ready;
   logic       key_req, load_state, sub_en, shift_en, mix_en, ark_en, inv, busy, done;
   logic [3:0] round_idx, key_idx;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
   logic       dec_mode;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   aes_round_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      .dec_mode   (dec_mode),
`endif
      .key_ready  (key_ready),
      .key_req    (key_req),
      .round_idx  (round_idx),
      .key_idx    (key_idx),
      .load_state (load_state),
      .sub_en     (sub_en),
      .shift_en   (shift_en),
      .mix_en     (mix_en),
      .ark_en     (ark_en),
      .inv        (inv),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      int stall_round;  // round whose KEYWAIT sees key_ready low (-1: none)
      int stall_len;
      bit restart;      // hold start high while busy and through DONE
      bit dec;
      int exp_lat;      // LOAD..DONE inclusive
      int exp_mix;
      int exp_ark;
      int exp_keyreq;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " done"}, 32'(done), 0);
      check({tag, " ctl"}, 32'({key_req, load_state, sub_en, shift_en, mix_en, ark_en}), 0);
   endtask

   task automatic run_block(input vec_t v, input int idx);
      int    cyc = 0, load_cyc = -1, done_cyc = -1, stalled = 0, last = 0;
      int    n_load = 0, n_sub = 0, n_shift = 0, n_mix = 0, n_ark = 0, n_kr = 0;
      int    onehot_err = 0, ark_err = 0, order_err = 0, kidx_err = 0;
      bit    finished = 0;
      string tag = $sformatf("vec%0d", idx);
      @(negedge clk);
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      dec_mode = v.dec;
`endif
      start     = 1'b1;
      key_ready = 1'b1;
      while (!finished && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = v.restart;
         if ($countones({load_state, sub_en, shift_en, mix_en, ark_en}) > 1) onehot_err++;
         if (load_state) begin
            n_load++;
            load_cyc = cyc;
         end
         if (sub_en) begin
            n_sub++;
            if (last != (v.dec ? 2 : 4)) order_err++;
            last = 1;
         end
         if (shift_en) begin
            n_shift++;
            if (v.dec ? !(last == 4 || last == 3) : (last != 1)) order_err++;
            last = 2;
         end
         if (mix_en) begin
            n_mix++;
            if (last != (v.dec ? 4 : 2)) order_err++;
            last = 3;
         end
         if (ark_en) begin
            if (key_idx != 4'(v.dec ? 10 - n_ark : n_ark)) ark_err++;
            if (round_idx != 4'(n_ark)) ark_err++;
            n_ark++;
            last = 4;
         end
         key_ready = 1'b1;
         if (key_req) begin
            n_kr++;
            if (int'(round_idx) == v.stall_round && stalled < v.stall_len) begin
               if (key_idx != 4'(v.dec ? 10 - v.stall_round : v.stall_round)) kidx_err++;
               key_ready = 1'b0;
               stalled++;
            end
         end
         if (done) begin
            done_cyc = cyc;
            finished = 1;
         end
      end
      check({tag, " finished"}, 32'(finished), 1);
      // Start (if restarting) stays high across DONE->IDLE; it must be ignored there.
      @(negedge clk);
      start = 1'b0;
      check_quiet({tag, " idle1"});
      check({tag, " round hold"}, 32'(round_idx), 10);
      check({tag, " inv hold"}, 32'(inv), 32'(v.dec));
      @(negedge clk);
      check_quiet({tag, " idle2"});
      check({tag, " latency"}, 32'(done_cyc - load_cyc + 1), 32'(v.exp_lat));
      check({tag, " load count"}, 32'(n_load), 1);
      check({tag, " load first"}, 32'(load_cyc), 1);
      check({tag, " sub count"}, 32'(n_sub), 10);
      check({tag, " shift count"}, 32'(n_shift), 10);
      check({tag, " mix count"}, 32'(n_mix), 32'(v.exp_mix));
      check({tag, " ark count"}, 32'(n_ark), 32'(v.exp_ark));
      check({tag, " keyreq cycles"}, 32'(n_kr), 32'(v.exp_keyreq));
      check({tag, " onehot"}, 32'(onehot_err), 0);
      check({tag, " ark key"}, 32'(ark_err), 0);
      check({tag, " stage order"}, 32'(order_err), 0);
      check({tag, " stall key_idx"}, 32'(kidx_err), 0);
   endtask

   initial begin
      int  cyc;
      bit  hit;
      rst       = 1'b1;
      start     = 1'b0;
      key_ready = 1'b0;
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      dec_mode  = 1'b0;
`endif
      vecs.push_back('{-1, 0, 1'b0, 1'b0, 53, 9, 11, 11});
      vecs.push_back('{ 3, 5, 1'b0, 1'b0, 58, 9, 11, 16});
      vecs.push_back('{ 0, 2, 1'b1, 1'b0, 55, 9, 11, 13});
      vecs.push_back('{10, 1, 1'b0, 1'b0, 54, 9, 11, 12});
`ifdef AES_ROUND_CTRL_DECRYPT_EN
      vecs.push_back('{-1, 0, 1'b0, 1'b1, 53, 9, 11, 11});
      vecs.push_back('{ 4, 3, 1'b1, 1'b1, 56, 9, 11, 14});
`endif
      vecs.push_back('{-1, 0, 1'b1, 1'b0, 53, 9, 11, 11});

      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_quiet("reset");
      check("reset round_idx", 32'(round_idx), 0);
      check("reset key_idx", 32'(key_idx), 0);
      check("reset inv", 32'(inv), 0);

      foreach (vecs[i]) run_block(vecs[i], i);

      // Reset in round 6 SubBytes aborts the block.
      @(negedge clk);
      start = 1'b1;
      cyc   = 0;
      hit   = 0;
      while (!hit && cyc < 200) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (sub_en && round_idx == 4'd6) hit = 1;
      end
      check("reach r6 sub", 32'(hit), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_quiet("midrst");
      check("midrst round_idx", 32'(round_idx), 0);
      check("midrst inv", 32'(inv), 0);
      hit = 0;
      repeat (60) begin
         @(negedge clk);
         if (busy || done) hit = 1;
      end
      check("midrst stays idle", 32'(hit), 0);

      // Reset wins over start in the same cycle.
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check_quiet("rst vs start");
      @(negedge clk);
      check_quiet("rst vs start next");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
